fifo_wr_arbiter: RTL

Write-side arbiter that shares the single write port of the asynchronous FIFO between `NREQ` requesters in the write-clock domain. It grants one requester at a time for a burst using round-robin order, and drives `winc`/`wdata` directly into the FIFO. It also gates every transfer with `wfull`, so the FIFO never sees a write attempt while full. It sits between the write-domain producers and the FIFO top level, entirely in `wclk`.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       gnt;
  logic                  busy;

  // master: the arbiter itself; slave: producers plus FIFO environment
  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, gnt, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, gnt, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the async FIFO write port
// Grants one requester per burst; wfull gates winc combinationally so the FIFO never overflows.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16,
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_wr_arbiter_if.master    bus
);

  localparam int            PW      = $clog2(NREQ);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            pick_hi_vld, pick_lo_vld;
  logic [PW-1:0]   pick_hi, pick_lo, pick_idx;
  logic            g_valid, g_last, accept;
  logic [DSIZE-1:0] g_data;
  logic [BW-1:0]   cnt_inc;

  // Round-robin: first valid above rr_ptr wins, otherwise wrap to the lowest valid.
  always_comb begin
    pick_hi_vld = 1'b0;
    pick_lo_vld = 1'b0;
    pick_hi     = '0;
    pick_lo     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i]) begin
        if (!pick_lo_vld) begin
          pick_lo_vld = 1'b1;
          pick_lo     = PW'(i);
        end
        if (!pick_hi_vld && (PW'(i) > rr_ptr_q)) begin
          pick_hi_vld = 1'b1;
          pick_hi     = PW'(i);
        end
      end
    end
    pick_idx = pick_hi_vld ? pick_hi : pick_lo;
  end

  // AND-OR mux keyed by the one-hot grant; all zero while idle.
  always_comb begin
    g_valid = |(gnt_q & bus.req_valid);
    g_last  = |(gnt_q & bus.req_last);
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      g_data = g_data | (bus.req_data[i*DSIZE +: DSIZE] & {DSIZE{gnt_q[i]}});
    end
  end

  assign accept  = (state_q == BURST) && g_valid && !bus.wfull;
  assign cnt_inc = beat_cnt_q + BW'(1);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= PW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_lo_vld) begin
          state_d    = BURST;
          gnt_d      = NREQ'(1) << pick_idx;
          rr_ptr_d   = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_d = cnt_inc;
          if (g_last || (cnt_inc == MAX_CNT)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (!bus.wfull && !g_valid) begin
          // Requester dropped valid while the FIFO had room: give the port away.
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.req_ready = ((state_q == BURST) && !bus.wfull) ? gnt_q : '0;
    bus.winc      = accept;
    bus.wdata     = g_data;
    bus.gnt       = gnt_q;
    bus.busy      = (state_q == BURST);
  end

  a_gnt_onehot: assert property (@(posedge wclk) disable iff (!wrst_n) $onehot0(gnt_q));
  a_cnt_bound:  assert property (@(posedge wclk) disable iff (!wrst_n) beat_cnt_q <= MAX_CNT);
  a_busy_gnt:   assert property (@(posedge wclk) disable iff (!wrst_n)
                                 (state_q == BURST) == (gnt_q != '0));

endmodule
